// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and branch tables for pc_sequencer (PC_RELATIVE_EN selects relative table)
package pc_seq_pkg;

   localparam int PC_W  = 10;
   localparam int IDX_W = 4;
   localparam int LUT_N = 1 << IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

   localparam logic [PC_W-1:0] BR_ABS_TABLE [LUT_N] = '{
      10'd8,  10'd14, 10'd4,  10'd0,
      10'd13, 10'd20, 10'd22, 10'd25,
      10'd32, 10'd34, 10'd21, 10'd26,
      10'd1,  10'd1,  10'd1,  10'd1
   };

`ifdef PC_RELATIVE_EN
   // Two's-complement offsets; the trailing 1s fall through to PC+1.
   localparam logic [PC_W-1:0] BR_REL_TABLE [LUT_N] = '{
      10'h3FC, 10'd6,   10'h3FE, 10'd3,
      10'd5,   10'h3F8, 10'd10,  10'd2,
      10'h3F0, 10'd4,   10'd7,   10'h3FF,
      10'd1,   10'd1,   10'd1,   10'd1
   };
`endif

endpackage

// File: rtl/branch_target_lut.sv
// rtl/branch_target_lut.sv - combinational index-to-target table (PC_RELATIVE_EN selects offsets)
module branch_target_lut
   import pc_seq_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [PC_W-1:0]  target
);

   always_comb begin
`ifdef PC_RELATIVE_EN
      target = BR_REL_TABLE[idx];
`else
      target = BR_ABS_TABLE[idx];
`endif
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, run/done handshake and perf counters (PC_RELATIVE_EN: relative branches)
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [PC_W-1:0]  StartAddr,
   input  logic             Halt,
   input  logic             Stall,
   input  logic             BranchEn,
   input  logic             Taken,
   input  logic [IDX_W-1:0] LutIdx,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCnt,
   output logic [7:0]       BranchCnt
);

   seq_state_e       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [7:0]       brc_q, brc_d;
   logic [PC_W-1:0]  lut_entry;
   logic [PC_W-1:0]  branch_pc;

   branch_target_lut u_lut (
      .idx    (LutIdx),
      .target (lut_entry)
   );

`ifdef PC_RELATIVE_EN
   assign branch_pc = pc_q + lut_entry;
`else
   assign branch_pc = lut_entry;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         cyc_q   <= '0;
         brc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cyc_q   <= cyc_d;
         brc_q   <= brc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cyc_d   = cyc_q;
      brc_d   = brc_q;
      if (Start) begin
         state_d = ST_LOAD;
         pc_d    = StartAddr;
         cyc_d   = '0;
         brc_d   = '0;
      end else begin
         case (state_q)
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
               // Cycle count includes stalled and halting cycles.
               if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
               if (Halt) begin
                  state_d = ST_DONE;
               end else if (Stall) begin
                  pc_d = pc_q;
               end else if (BranchEn && Taken) begin
                  pc_d = branch_pc;
                  if (brc_q != 8'hFF) brc_d = brc_q + 8'd1;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   assign ProgCtr   = pc_q;
   assign Running   = (state_q == ST_RUN);
   assign Done      = (state_q == ST_DONE);
   assign CycleCnt  = cyc_q;
   assign BranchCnt = brc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized bench for pc_sequencer against a behavioural model (PC_RELATIVE_EN aware)
module tb_pc_sequencer;

   localparam int PC_W  = 10;
   localparam int IDX_W = 4;
   localparam int CNT_W = 16;
   localparam int PC_MOD  = 1 << PC_W;
   localparam int CYC_MAX = (1 << CNT_W) - 1;
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             Start;
   logic [PC_W-1:0]  StartAddr;
   logic             Halt, Stall, BranchEn, Taken;
   logic [IDX_W-1:0] LutIdx;
   logic [PC_W-1:0]  ProgCtr;
   logic             Running, Done;
   logic [CNT_W-1:0] CycleCnt;
   logic [7:0]       BranchCnt;

   pc_sequencer #(.CNT_W(CNT_W)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .StartAddr (StartAddr),
      .Halt      (Halt),
      .Stall     (Stall),
      .BranchEn  (BranchEn),
      .Taken     (Taken),
      .LutIdx    (LutIdx),
      .ProgCtr   (ProgCtr),
      .Running   (Running),
      .Done      (Done),
      .CycleCnt  (CycleCnt),
      .BranchCnt (BranchCnt)
   );

   always #5 Clk = ~Clk;

`ifdef PC_RELATIVE_EN
   int tbl [16] = '{-4, 6, -2, 3, 5, -8, 10, 2, -16, 4, 7, -1, 1, 1, 1, 1};
`else
   int tbl [16] = '{8, 14, 4, 0, 13, 20, 22, 25, 32, 34, 21, 26, 1, 1, 1, 1};
`endif

   int m_mode, m_pc, m_cyc, m_br;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_pc = 0; m_cyc = 0; m_br = 0;
   endtask

   task automatic model_step(input bit st, input int sa, input bit h, input bit s,
                             input bit be, input bit tk, input int idx);
      if (st) begin
         m_mode = M_LOAD; m_pc = sa; m_cyc = 0; m_br = 0;
      end else if (m_mode == M_LOAD) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         m_cyc = (m_cyc < CYC_MAX) ? m_cyc + 1 : CYC_MAX;
         if (h) m_mode = M_DONE;
         else if (s) m_pc = m_pc;
         else if (be && tk) begin
`ifdef PC_RELATIVE_EN
            m_pc = (m_pc + tbl[idx] + PC_MOD) % PC_MOD;
`else
            m_pc = tbl[idx];
`endif
            m_br = (m_br < 255) ? m_br + 1 : 255;
         end else m_pc = (m_pc + 1) % PC_MOD;
      end
   endtask

   task automatic check_all(input string ph);
      check({ph, ".pc"},   ProgCtr,   m_pc);
      check({ph, ".run"},  Running,   m_mode == M_RUN);
      check({ph, ".done"}, Done,      m_mode == M_DONE);
      check({ph, ".cyc"},  CycleCnt,  m_cyc);
      check({ph, ".brc"},  BranchCnt, m_br);
   endtask

   // Called at a negedge: drive, advance the model, take one edge, check at the next negedge.
   task automatic step(input string ph, input bit st, input int sa, input bit h, input bit s,
                       input bit be, input bit tk, input int idx, input bit chk);
      Start = st; StartAddr = sa[PC_W-1:0]; Halt = h; Stall = s;
      BranchEn = be; Taken = tk; LutIdx = idx[IDX_W-1:0];
      model_step(st, sa, h, s, be, tk, idx);
      @(posedge Clk);
      @(negedge Clk);
      if (chk) check_all(ph);
   endtask

   task automatic free(input string ph, input int n);
      for (int i = 0; i < n; i++) step(ph, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      Reset = 1'b1; Start = 0; StartAddr = '0; Halt = 0; Stall = 0;
      BranchEn = 0; Taken = 0; LutIdx = '0;
      model_reset();
      @(negedge Clk); @(negedge Clk);
      check_all("reset");
      Reset = 1'b0;

      // Asynchronous reset mid-run at PC=5
      step("rst", 1, 3, 0, 0, 0, 0, 0, 1);
      free("rst", 3);
      check("rst.pc5", ProgCtr, 5);
      #2 Reset = 1'b1;
      #1;
      model_reset();
      check("arst.pc", ProgCtr, 0);
      check("arst.run", Running, 0);
      check("arst.cyc", CycleCnt, 0);
      check("arst.brc", BranchCnt, 0);
      @(negedge Clk);
      Reset = 1'b0;
      check_all("arst");

      // Start and free run
      step("start", 1, 3, 0, 0, 0, 0, 0, 1);
      check("load.pc", ProgCtr, 3);
      check("load.run", Running, 0);
      step("start", 0, 0, 0, 0, 0, 0, 0, 1);
      check("run1.run", Running, 1);
      free("start", 4);
      check("free4.pc", ProgCtr, 7);
      check("free4.cyc", CycleCnt, 4);

      // Branch handling
      step("br", 1, 10, 0, 0, 0, 0, 0, 1);
      step("br", 0, 0, 0, 0, 0, 0, 0, 1);
      step("br", 0, 0, 0, 0, 1, 1, 1, 1);
`ifndef PC_RELATIVE_EN
      check("br1.pc", ProgCtr, 14);
`endif
      check("br1.brc", BranchCnt, 1);
      step("br", 1, 10, 0, 0, 0, 0, 0, 1);
      step("br", 0, 0, 0, 0, 0, 0, 0, 1);
      step("br", 0, 0, 0, 0, 1, 0, 1, 1);
      check("brnt.pc", ProgCtr, 11);
      step("br", 0, 0, 0, 0, 1, 1, 13, 1);
`ifndef PC_RELATIVE_EN
      check("br13.pc", ProgCtr, 1);
`endif

      // Halt beats stall and branch; DONE ignores controls
      step("prio", 1, 20, 0, 0, 0, 0, 0, 1);
      step("prio", 0, 0, 0, 0, 0, 0, 0, 1);
      step("prio", 0, 0, 1, 1, 1, 1, 2, 1);
      check("prio.done", Done, 1);
      check("prio.pc", ProgCtr, 20);
      check("prio.brc", BranchCnt, 0);
      for (int i = 0; i < 4; i++) step("done", 0, 0, i[0], i[1], 1, 1, i, 1);
      step("restart", 1, 5, 0, 0, 0, 0, 0, 1);
      step("restart", 0, 0, 0, 0, 0, 0, 0, 1);
      check("restart.run", Running, 1);

      // PC wrap
      step("wrap", 1, 1022, 0, 0, 0, 0, 0, 1);
      step("wrap", 0, 0, 0, 0, 0, 0, 0, 1);
      free("wrap", 1); check("wrap.1023", ProgCtr, 1023);
      free("wrap", 1); check("wrap.0", ProgCtr, 0);
      free("wrap", 1); check("wrap.1", ProgCtr, 1);

`ifdef PC_RELATIVE_EN
      step("rel", 1, 8, 0, 0, 0, 0, 0, 1);
      step("rel", 0, 0, 0, 0, 0, 0, 0, 1);
      step("rel", 0, 0, 0, 0, 1, 1, 0, 1);
      check("rel.m4", ProgCtr, 4);
      step("rel", 0, 0, 0, 0, 1, 1, 12, 1);
      check("rel.p1", ProgCtr, 5);
`endif

      // CycleCnt saturation, holding the PC with Stall
      step("csat", 1, 0, 0, 0, 0, 0, 0, 1);
      step("csat", 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < CYC_MAX + 4; i++) step("csat", 0, 0, 0, 1, 0, 0, 0, 0);
      check_all("csat");
      check("csat.max", CycleCnt, 16'hFFFF);
      step("csat", 0, 0, 0, 1, 0, 0, 0, 1);
      check("csat.hold", CycleCnt, 16'hFFFF);

      // BranchCnt saturation
      step("bsat", 1, 0, 0, 0, 0, 0, 0, 1);
      step("bsat", 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 300; i++) step("bsat", 0, 0, 0, 0, 1, 1, $urandom_range(15), 1);
      check("bsat.max", BranchCnt, 255);

      // Random program traffic
      for (int i = 0; i < 3000; i++) begin
         step("rand", ($urandom_range(63) == 0), $urandom_range(PC_MOD - 1),
              ($urandom_range(31) == 0), ($urandom_range(7) == 0),
              ($urandom_range(3) == 0), $urandom_range(1), $urandom_range(15), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle LFSR core. Owns the 10-bit program counter, the run/done handshake with the testbench, and branch-target selection through a 16-entry index-to-target table. The decoder supplies halt/branch controls and a 4-bit table index, and the sequencer drives the next instruction address to instruction memory every cycle. It also keeps cycle and taken-branch counters for performance reporting.

## Interface
- PC_W, 10, program counter / target width
- IDX_W, 4, branch table index width
- CNT_W, 16, cycle counter width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  level; while high, the core is held at StartAddr
- StartAddr  in  PC_W  program entry address, sampled while Start is high
- Halt  in  1  decoded halt instruction in the current cycle
- Stall  in  1  hold the PC this cycle (multi-cycle datapath op)
- BranchEn  in  1  current instruction is a branch
- Taken  in  1  branch condition true (ignored unless BranchEn)
- LutIdx  in  IDX_W  branch table index from the instruction field
- ProgCtr  out  PC_W  current instruction address (registered)
- Running  out  1  state is RUN
- Done  out  1  state is DONE; the program has finished
- CycleCnt  out  CNT_W  cycles spent in RUN, saturating
- BranchCnt  out  8  taken branches in RUN, saturating

## Operation
- States: IDLE, LOAD, RUN, DONE. The state register updates on Clk and is cleared by Reset.
- Reset (any time, including mid-run) drives the following asynchronously:
  - state to IDLE
  - ProgCtr, CycleCnt and BranchCnt to 0
  - Running and Done to 0
- Start handling, from any state:
  - Start=1 moves the block to LOAD, loads ProgCtr from StartAddr, and clears both counters.
  - LOAD with Start=0 moves to RUN on the next edge. The first instruction fetched is at StartAddr.
- Next-PC priority in RUN:
  1. Halt: go to DONE and hold ProgCtr.
  2. Stall: hold ProgCtr.
  3. BranchEn&&Taken: load the branch target and increment BranchCnt.
  4. Otherwise: ProgCtr+1.
- Halt and Stall asserted together: Halt wins. Halt together with a taken branch: the PC holds and the branch is not counted.
- Increment wraps modulo 2^PC_W: 1023 goes to 0.
- CycleCnt increments every RUN cycle, including stalled cycles. It saturates at all ones; BranchCnt saturates at 255.
- DONE holds ProgCtr and both counters stable until the next Start. In IDLE and DONE, Halt, Stall and the branch inputs are ignored.
- Branch table contents (absolute targets), by index:
  - 0→8, 1→14, 2→4, 3→0
  - 4→13, 5→20, 6→22, 7→25
  - 8→32, 9→34, 10→21, 11→26
  - 12–15→1 (default)

## Timing
- ProgCtr is registered. The table lookup and next-PC selection are combinational in the same cycle, so a taken branch appears on ProgCtr one edge after BranchEn/Taken are sampled.
- Running and Done are decoded from the state register; they carry no extra latency.
- Start is a synchronous level. The minimum Start pulse is one cycle: IDLE→LOAD→RUN, so the first RUN cycle is two edges after Start rises.

## Configuration
- PC_RELATIVE_EN defined:
  - Table entries are treated as PC_W-bit two's-complement offsets, and a taken branch loads ProgCtr+entry modulo 2^PC_W.
  - The default entry of 1 behaves as fall-through.
  - The table contents are replaced by the relative set in the package.
- PC_RELATIVE_EN not defined: entries are absolute targets, loaded directly.

## Structure
- Package pc_seq_pkg holds:
  - the state enum
  - the PC_W/IDX_W localparams
  - the absolute table constant
  - the relative table constant, under the macro
- Sub-module branch_target_lut is purely combinational: index in, PC_W target out. It is read from the package constant and instantiated once.

## Test plan
- Reset: Reset pulse in mid-RUN with ProgCtr=5 → ProgCtr=0, IDLE, Running=0 immediately (async), counters=0.
- Start and run: Start=1 with StartAddr=3 for 1 cycle → LOAD with ProgCtr=3; then RUN; after 4 free cycles ProgCtr=7 and CycleCnt=4.
- Absolute branch: BranchEn=1, Taken=1, LutIdx=1 at PC=10 → PC=14, BranchCnt=1. With Taken=0 → PC=11. Using LutIdx=13 → PC=1.
- Priority: Halt+Stall+taken branch in one cycle at PC=20 → DONE, PC=20, BranchCnt unchanged, Done=1. A later Start restarts the program.
- Wrap and saturation:
  - StartAddr=1022, run 3 cycles → PC=1023, 0, 1.
  - Force CycleCnt to 16'hFFFF → it stays at FFFF.
- PC_RELATIVE_EN build: relative entry −4 (10'h3FC) at PC=8, taken → PC=4. Entry +1 → PC+1.
